// File: rtl/par2ser_pkg.sv
// Shared types and helpers for the par2ser_flex parallel-to-serial converter.
package par2ser_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int num_slices(input int bw_in, input int ser_bw);
    return bw_in / ser_bw;
  endfunction

  // A word must split into a whole, non-zero number of slices.
  function automatic bit cfg_valid(input int bw_in, input int ser_bw);
    return (ser_bw > 0) && (bw_in >= ser_bw) && ((bw_in % ser_bw) == 0);
  endfunction

endpackage

// File: rtl/par2ser_flex_if.sv
// Word-in / slice-out handshake bundle for par2ser_flex.
interface par2ser_flex_if #(
  parameter int NO_CH  = 10,
  parameter int BW_IN  = 12,
  parameter int SER_BW = 4
);
  logic                           vld_in;
  logic                           rdy_in;
  logic [NO_CH-1:0][BW_IN-1:0]    data_in;
  logic                           vld_out;
  logic                           rdy_out;
  logic [NO_CH-1:0][SER_BW-1:0]   data_out;
  logic                           last_out;

  modport master (
    output vld_in, data_in, rdy_out,
    input  rdy_in, vld_out, data_out, last_out
  );

  modport slave (
    input  vld_in, data_in, rdy_out,
    output rdy_in, vld_out, data_out, last_out
  );
endinterface

// File: rtl/par2ser_ctrl.sv
// Lane-shared control for par2ser_flex: FSM, slice index, hold-full flag and
// the load/shift/bypass selects driving every channel's shift and hold registers.
module par2ser_ctrl
  import par2ser_pkg::*;
#(
  parameter int NO_SLICES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic vld_in,
  input  logic rdy_out,
  output logic rdy_in,
  output logic vld_out,
  output logic last_out,
  output logic load_in,
  output logic load_hold,
  output logic shift_en,
  output logic hold_we
);

  localparam int IDX_W = $clog2(NO_SLICES) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NO_SLICES - 1);

  state_t           state_r, state_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic             hold_full_r, hold_full_s;
  logic             vld_r, last_r, rdy_r;
  logic             accept_s, xfer_s, last_xfer_s;

  assign accept_s    = vld_in && rdy_r;
  assign xfer_s      = vld_r && rdy_out;
  assign last_xfer_s = xfer_s && (idx_r == LAST_IDX);

  // Next-state, index and datapath select decode.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    hold_full_s = hold_full_r;
    load_in     = 1'b0;
    load_hold   = 1'b0;
    shift_en    = 1'b0;
    hold_we     = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          load_in = 1'b1;
          idx_s   = {IDX_W{1'b0}};
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (last_xfer_s) begin
          idx_s = {IDX_W{1'b0}};
          if (hold_full_r) begin
            load_hold   = 1'b1;
            hold_full_s = 1'b0;
          end else if (accept_s) begin
            load_in = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end else if (xfer_s) begin
          shift_en = 1'b1;
          idx_s    = idx_r + IDX_W'(1);
        end else begin
          idx_s = idx_r;
        end
        // An accept that is not consumed by the bypass parks in the hold register.
        if (accept_s && !last_xfer_s) begin
          hold_we     = 1'b1;
          hold_full_s = 1'b1;
        end else begin
          hold_we = 1'b0;
        end
      end
      default: begin
        state_s     = IDLE;
        idx_s       = {IDX_W{1'b0}};
        hold_full_s = 1'b0;
      end
    endcase
  end

  // State, index and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      idx_r       <= {IDX_W{1'b0}};
      hold_full_r <= 1'b0;
      vld_r       <= 1'b0;
      last_r      <= 1'b0;
      rdy_r       <= 1'b1;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      hold_full_r <= hold_full_s;
      vld_r       <= (state_s == SHIFT);
      last_r      <= (state_s == SHIFT) && (idx_s == LAST_IDX);
      rdy_r       <= !hold_full_s;
    end
  end

  assign rdy_in   = rdy_r;
  assign vld_out  = vld_r;
  assign last_out = last_r;

endmodule

// File: rtl/par2ser_flex.sv
// par2ser_flex: NO_CH x BW_IN parallel word in, BW_IN/SER_BW slices of SER_BW bits out.
// Define PAR2SER_MSB_FIRST_EN to emit the most-significant slice first.
module par2ser_flex
  import par2ser_pkg::*;
#(
  parameter int NO_CH  = 10,
  parameter int BW_IN  = 12,
  parameter int SER_BW = 4
) (
  input logic           clk,
  input logic           rst,
  par2ser_flex_if.slave bus
);

  localparam int NO_SLICES = num_slices(BW_IN, SER_BW);

  if (!cfg_valid(BW_IN, SER_BW)) begin : g_cfg_err
    $error("par2ser_flex: BW_IN must be a non-zero multiple of SER_BW");
  end

  logic rdy_s, vld_s, last_s;
  logic load_in_s, load_hold_s, shift_en_s, hold_we_s;

  par2ser_ctrl #(
    .NO_SLICES (NO_SLICES)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .vld_in    (bus.vld_in),
    .rdy_out   (bus.rdy_out),
    .rdy_in    (rdy_s),
    .vld_out   (vld_s),
    .last_out  (last_s),
    .load_in   (load_in_s),
    .load_hold (load_hold_s),
    .shift_en  (shift_en_s),
    .hold_we   (hold_we_s)
  );

  assign bus.rdy_in   = rdy_s;
  assign bus.vld_out  = vld_s;
  assign bus.last_out = last_s;

  for (genvar ch = 0; ch < NO_CH; ch++) begin : g_lane
    logic [BW_IN-1:0] sh_r;
    logic [BW_IN-1:0] hold_r;

    // Per-channel shift register: load from input, from hold, or shift one slice.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sh_r <= {BW_IN{1'b0}};
      end else if (load_in_s) begin
        sh_r <= bus.data_in[ch];
      end else if (load_hold_s) begin
        sh_r <= hold_r;
      end else if (shift_en_s) begin
`ifdef PAR2SER_MSB_FIRST_EN
        sh_r <= sh_r << SER_BW;
`else
        sh_r <= sh_r >> SER_BW;
`endif
      end else begin
        sh_r <= sh_r;
      end
    end

    // Per-channel holding register for the word queued behind the one shifting.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        hold_r <= {BW_IN{1'b0}};
      end else if (hold_we_s) begin
        hold_r <= bus.data_in[ch];
      end else begin
        hold_r <= hold_r;
      end
    end

`ifdef PAR2SER_MSB_FIRST_EN
    assign bus.data_out[ch] = sh_r[BW_IN-1 -: SER_BW];
`else
    assign bus.data_out[ch] = sh_r[SER_BW-1:0];
`endif
  end

endmodule

// File: tb/tb_par2ser_flex.sv
// Self-checking bench for par2ser_flex: directed scenarios plus random traffic
// checked against a slice-queue model of a 2-word buffer.
module tb_par2ser_flex;

  localparam int NC = 2;
  localparam int BW = 12;
  localparam int SB = 4;
  localparam int NS = BW / SB;

`ifdef PAR2SER_MSB_FIRST_EN
  localparam logic [3:0] S1_CH0_FIRST = 4'hA;
  localparam logic [3:0] S1_CH1_FIRST = 4'h1;
  localparam logic [3:0] BYP_FIRST    = 4'h7;
`else
  localparam logic [3:0] S1_CH0_FIRST = 4'hC;
  localparam logic [3:0] S1_CH1_FIRST = 4'h3;
  localparam logic [3:0] BYP_FIRST    = 4'h9;
`endif

  typedef logic [NC-1:0][BW-1:0] word_t;
  typedef struct packed {
    logic [NC-1:0][SB-1:0] data;
    logic                  last;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t exp_q[$];
  int   words_out = 0;
  bit   acc_r;

  par2ser_flex_if #(.NO_CH(NC), .BW_IN(BW), .SER_BW(SB)) bus ();

  par2ser_flex #(.NO_CH(NC), .BW_IN(BW), .SER_BW(SB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [SB-1:0] slice_of(input logic [BW-1:0] v, input int k);
    int pos;
`ifdef PAR2SER_MSB_FIRST_EN
    pos = NS - 1 - k;
`else
    pos = k;
`endif
    return SB'((int'(v) / (1 << (SB * pos))) % (1 << SB));
  endfunction

  // One clock: compare outputs with the model, advance the model, step the clock.
  task automatic cycle();
    bit   xfer;
    ent_t e;
    chk("vld_out", bus.vld_out, exp_q.size() != 0);
    chk("rdy_in", bus.rdy_in, words_out < 2);
    if (exp_q.size() != 0) begin
      chk("data_out", bus.data_out, exp_q[0].data);
      chk("last_out", bus.last_out, exp_q[0].last);
    end else begin
      chk("last_idle", bus.last_out, 1'b0);
    end
    acc_r = bus.vld_in && (words_out < 2);
    xfer  = (exp_q.size() != 0) && bus.rdy_out;
    if (xfer) begin
      if (exp_q[0].last) words_out--;
      void'(exp_q.pop_front());
    end
    if (acc_r) begin
      for (int k = 0; k < NS; k++) begin
        for (int c = 0; c < NC; c++) e.data[c] = slice_of(bus.data_in[c], k);
        e.last = (k == NS - 1);
        exp_q.push_back(e);
      end
      words_out++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input word_t w);
    bus.vld_in  = 1'b1;
    bus.data_in = w;
    for (int i = 0; i < 64 && bus.vld_in; i++) begin
      cycle();
      if (acc_r) bus.vld_in = 1'b0;
    end
    if (bus.vld_in) begin
      chk("accept_timeout", bus.vld_in, 1'b0);
      bus.vld_in = 1'b0;
    end
  endtask

  initial begin
    rst         = 1'b0;
    bus.vld_in  = 1'b0;
    bus.data_in = '0;
    bus.rdy_out = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", bus.vld_out, 1'b0);
    chk("rst_last", bus.last_out, 1'b0);
    chk("rst_data", bus.data_out, 8'h00);
    chk("rst_rdy", bus.rdy_in, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single word
    bus.rdy_out = 1'b1;
    drive_word({12'h123, 12'hABC});
    chk("s1_first_ch0", bus.data_out[0], S1_CH0_FIRST);
    chk("s1_first_ch1", bus.data_out[1], S1_CH1_FIRST);
    repeat (4) cycle();

    // Back-to-back through the hold register
    drive_word({12'h111, 12'h111});
    drive_word({12'h222, 12'h222});
    chk("b2b_rdy_low", bus.rdy_in, 1'b0);
    repeat (7) cycle();

    // Backpressure on slice 1
    drive_word({12'h000, 12'hABC});
    cycle();
    bus.rdy_out = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stall_hold", bus.data_out[0], 4'hB);
      cycle();
    end
    bus.rdy_out = 1'b1;
    repeat (4) cycle();

    // Bypass: next word lands exactly on the last slice
    drive_word({12'h456, 12'h456});
    cycle();
    cycle();
    drive_word({12'h789, 12'h789});
    chk("bypass_rdy", bus.rdy_in, 1'b1);
    chk("bypass_first", bus.data_out[0], BYP_FIRST);
    repeat (4) cycle();

    // Reset mid-word
    drive_word({12'hFED, 12'hCBA});
    cycle();
    rst = 1'b0;
    #1;
    chk("mid_rst_vld", bus.vld_out, 1'b0);
    chk("mid_rst_last", bus.last_out, 1'b0);
    chk("mid_rst_data", bus.data_out, 8'h00);
    chk("mid_rst_rdy", bus.rdy_in, 1'b1);
    exp_q.delete();
    words_out = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) cycle();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      bus.rdy_out = ($urandom_range(0, 3) != 0);
      if (!bus.vld_in && ($urandom_range(0, 2) != 0)) begin
        bus.vld_in  = 1'b1;
        bus.data_in = word_t'({$urandom(), $urandom()});
      end
      cycle();
      if (acc_r) bus.vld_in = 1'b0;
    end
    bus.vld_in  = 1'b0;
    bus.rdy_out = 1'b1;
    repeat (10) cycle();
    chk("drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/par2ser_flex.md
# par2ser_flex

Parallel-to-serial converter that feeds serial-input pooling and compute stages. It accepts one parallel word of `NO_CH` channels × `BW_IN` bits through a valid/ready handshake. It emits each word as `BW_IN/SER_BW` consecutive `SER_BW`-bit slices per channel, least-significant slice first, with a per-slice valid and downstream backpressure. A one-word holding register lets the upstream deliver the next word while the current one is being shifted out, so back-to-back words stream without gaps.

## Interface
Parameters:
- `NO_CH`, 10: number of parallel channels.
- `BW_IN`, 12: bits per channel word. Must be a multiple of `SER_BW`.
- `SER_BW`, 4: bits per emitted slice.

Ports:
- `clk`, input, 1: the single clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `vld_in`, input, 1: upstream word valid.
- `rdy_in`, output, 1: block can accept a word this cycle.
- `data_in`, input, `[NO_CH-1:0][BW_IN-1:0]`: parallel word.
- `vld_out`, output, 1: slice valid.
- `rdy_out`, input, 1: downstream accepts a slice this cycle.
- `data_out`, output, `[NO_CH-1:0][SER_BW-1:0]`: current slice, all channels.
- `last_out`, output, 1: current slice is the final slice of its word.

## Operation
- `NO_SLICES = BW_IN/SER_BW`. The slice index counter is `$clog2(NO_SLICES)+1` bits wide.
- Handshakes:
  - Input accept = `vld_in && rdy_in`.
  - Slice transfer = `vld_out && rdy_out`.
- Storage: a per-channel shift register `sh[i]` (`BW_IN` bits), plus a holding register `hold` with a `hold_full` flag.
- `rdy_in = !hold_full`. This is a registered flag, with no combinational path from `rdy_out`.
- FSM states:
  - `IDLE`: `vld_out=0`. On accept, load `sh`, reset the index to 0, and go to `SHIFT`.
  - `SHIFT`: `vld_out=1`. On a transfer that is not the last slice, shift `sh[i]` right by `SER_BW` and increment the index.
  - `SHIFT`, on a transfer of the last slice:
    - If `hold_full`: load `sh` from `hold`, clear `hold_full`, set index to 0, stay in `SHIFT`.
    - Else, if an accept occurs in the same cycle: load `sh` directly from `data_in` (bypass), stay in `SHIFT`.
    - Else: go to `IDLE`.
  - `SHIFT`, on an accept that does not coincide with the bypass case: write `hold` and set `hold_full`.
- Output signals:
  - `data_out[i] = sh[i][SER_BW-1:0]`.
  - `last_out = (index == NO_SLICES-1) && vld_out`.
- Stall: while `vld_out && !rdy_out`, `data_out`, `last_out` and the index hold stable.
- `NO_SLICES == 1`: every transfer is last, so the block degenerates to a 2-deep pipeline FIFO.
- Data is passed bit-exact, with no sign handling.

## Timing
- Reset values (asserted asynchronously): `vld_out=0`, `last_out=0`, `data_out=0`, `rdy_in=1`, `hold_full=0`, state `IDLE`, index 0.
- Latency: a word accepted at edge t drives its first slice at t+1.
- Throughput: one word per `NO_SLICES` cycles when `rdy_out` stays high. `vld_out` stays continuously high across word boundaries if each next word arrives before its predecessor's last slice.
- Upstream stall: `rdy_in` falls the cycle after `hold` fills. It rises the cycle after `hold` is drained into `sh`.
- Reset mid-word: the partial word and the `hold` contents are discarded. No slice is emitted after reset release until a new accept.
- `vld_in` asserted while `rdy_in=0` is ignored. Upstream must hold `vld_in` and `data_in` until accepted.

## Configuration
- `PAR2SER_MSB_FIRST_EN` defined: slices are emitted most-significant first. `data_out[i] = sh[i][BW_IN-1 -: SER_BW]` and the shift is left.
- Undefined (default): least-significant slice first, as the downstream serial pooling stages require.
- Handshake, timing and `last_out` are identical in both modes.

## Structure
- Shared package `par2ser_pkg` holds:
  - the `state_t` enum (`IDLE`, `SHIFT`);
  - a `num_slices(bw_in, ser_bw)` function;
  - an elaboration check that `BW_IN % SER_BW == 0`.
- One sub-module, `par2ser_ctrl`, holds the FSM, index counter, `hold_full` flag and the load/shift/bypass selects. It is shared by all lanes.
- The per-channel `sh` and `hold` datapath is a generate loop in the top level.

## Test plan
All scenarios use `NO_CH=2`, `BW_IN=12`, `SER_BW=4`.
1. Single word, `rdy_out=1`. ch0=`12'hABC`, ch1=`12'h123` → three cycles with ch0 `C,B,A` and ch1 `3,2,1`. `last_out` is high on the 3rd cycle only, then `vld_out=0`.
2. Back-to-back: `vld_in` held high with `12'h111` then `12'h222`. → six consecutive valid slices `1,1,1,2,2,2` with no gap. `rdy_in` drops while `hold` is full.
3. Backpressure: `rdy_out` low for 4 cycles on slice 1 of `12'hABC`. → `data_out`=`B` held stable, then `A` follows, and no slice is lost.
4. Bypass: a new word is accepted in the same cycle the last slice transfers with `hold` empty. → its first slice appears the next cycle and `hold_full` stays 0.
5. Reset mid-word: `rst` low after slice 0. → outputs clear immediately, and no stale slice appears after release.
6. With `PAR2SER_MSB_FIRST_EN` defined, `12'hABC` → `A,B,C`.
